spi_ram_burst_slave: RTL and testbench

- SPI slave with built-in single-port RAM, parametrised in data width, address width and depth.
- Adds auto-incrementing burst write/read within one ss_n frame, a saturating write-count status read, and an error pulse for aborted frames.
- `clk` is the serial bit clock: one MOSI bit is sampled per rising edge while ss_n is low.
- Sits at chip top as the host-facing register/memory port.

---
 rtl/spi_ram_burst_slave_if.sv | 20 ++
 rtl/spi_ram_burst_slave.sv | 197 +++++++++++++++++++
 tb/tb_spi_ram_burst_slave.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_burst_slave_if.sv
// ---------------------------------------------------------------------------
// spi_ram_burst_slave_if
//   Serial-side signal bundle of the SPI RAM burst slave.
//   ss_n  : slave select, active-low; high ends the frame
//   MOSI  : serial data in, MSB first
//   MISO  : serial data out, registered, MSB first
//   busy  : high while a frame is in progress
//   err   : one-cycle pulse on a bad or aborted frame
//   master modport is the host side, slave modport is the RAM slave side.
// ---------------------------------------------------------------------------
interface spi_ram_burst_slave_if;
    logic ss_n;
    logic MOSI;
    logic MISO;
    logic busy;
    logic err;

    modport master (output ss_n, MOSI, input MISO, busy, err);
    modport slave  (input ss_n, MOSI, output MISO, busy, err);
endinterface

// File: rtl/spi_ram_burst_slave.sv
// ---------------------------------------------------------------------------
// spi_ram_burst_slave
//   SPI slave fronting a single-port RAM. A frame (ss_n low) starts with a
//   2-bit opcode: 00 WRITE, 01 READ, 10 STATUS, 11 reserved. WRITE/READ take
//   an ADDR_WIDTH address and then burst words with auto-increment that wraps
//   at MEM_DEPTH-1. STATUS streams the saturating write count repeatedly.
//   Ports:
//     clk   : serial bit clock, one MOSI bit per rising edge while ss_n low
//     rst_n : asynchronous active-low reset
//     bus   : ss_n/MOSI in, MISO/busy/err out (slave modport)
// ---------------------------------------------------------------------------
module spi_ram_burst_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_ram_burst_slave_if.slave bus
);

    localparam int CNT_W = $clog2((ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH) + 1);

    localparam logic [CNT_W-1:0]      ADDR_LAST_BIT = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]      DATA_LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]      DATA_BITS     = CNT_W'(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT     = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_STATUS = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RTURN,
        S_RDATA,
        S_IGNORE
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   sh_q, sh_d;
    logic [DATA_WIDTH-1:0]   pref_q, pref_d;
    logic [DATA_WIDTH-1:0]   wcount_q, wcount_d;
    logic                    miso_q, miso_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic                    mem_we;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]   addr_shift;
    logic [ADDR_WIDTH-1:0]   addr_mod;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [DATA_WIDTH-1:0]   word_in;
    logic [DATA_WIDTH-1:0]   sh_shifted;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic [DATA_WIDTH-1:0]   load_word;
    logic                    is_status;

    assign addr_shift = ADDR_WIDTH'({addr_q, bus.MOSI});
    // Out-of-range addresses fold back into the array instead of aliasing.
    assign addr_mod   = ADDR_WIDTH'({1'b0, addr_shift} % DEPTH_EXT);
    assign addr_next  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
    assign word_in    = DATA_WIDTH'({sh_q, bus.MOSI});
    assign sh_shifted = sh_q << 1;
    assign mem_rdata  = mem[addr_q];
    assign is_status  = (op_q == OP_STATUS);
    // First word comes straight from RAM; later words come from the prefetch.
    assign load_word  = is_status ? wcount_q
                      : (state_q == S_RTURN) ? mem_rdata : pref_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        pref_d   = pref_q;
        wcount_d = wcount_q;
        miso_d   = miso_q;
        err_d    = 1'b0;
        mem_we   = 1'b0;

        if (bus.ss_n) begin
            state_d = S_IDLE;
            miso_d  = 1'b0;
            cnt_d   = '0;
            err_d   = (state_q == S_CMD) || (state_q == S_ADDR) ||
                      ((state_q == S_WDATA) && (cnt_q != '0));
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    op_d    = {bus.MOSI, 1'b0};
                    state_d = S_CMD;
                end
                S_CMD: begin
                    op_d  = {op_q[1], bus.MOSI};
                    cnt_d = '0;
                    if (op_q[1] == 1'b0)                        state_d = S_ADDR;
                    else if ({op_q[1], bus.MOSI} == OP_RSVD)    state_d = S_IGNORE;
                    else                                        state_d = S_RTURN;
                end
                S_ADDR: begin
                    if (cnt_q == ADDR_LAST_BIT) begin
                        addr_d  = addr_mod;
                        cnt_d   = '0;
                        state_d = (op_q == OP_READ) ? S_RTURN : S_WDATA;
                    end else begin
                        addr_d = addr_shift;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
                S_WDATA: begin
                    if (cnt_q == DATA_LAST_BIT) begin
                        mem_we   = 1'b1;
                        cnt_d    = '0;
                        addr_d   = addr_next;
                        wcount_d = (wcount_q == '1) ? wcount_q : wcount_q + 1'b1;
                    end else begin
                        sh_d  = word_in;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RTURN, S_RDATA: begin
                    // cnt counts bits already presented on MISO for this word.
                    if ((state_q == S_RTURN) || (cnt_q == DATA_BITS)) begin
                        sh_d    = load_word;
                        miso_d  = load_word[DATA_WIDTH-1];
                        cnt_d   = CNT_W'(1);
                        state_d = S_RDATA;
                        if (!is_status) addr_d = addr_next;
                    end else begin
                        sh_d   = sh_shifted;
                        miso_d = sh_shifted[DATA_WIDTH-1];
                        cnt_d  = cnt_q + 1'b1;
                        if ((cnt_q == CNT_W'(1)) && !is_status) pref_d = mem_rdata;
                    end
                end
                S_IGNORE: begin
                    miso_d = 1'b0;
                    err_d  = (cnt_q == '0);
                    cnt_d  = CNT_W'(1);
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            state_q  <= S_IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
            pref_q   <= '0;
            wcount_q <= '0;
            miso_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            pref_q   <= pref_d;
            wcount_q <= wcount_d;
            miso_q   <= miso_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // NOTE: the RAM array has no reset; contents survive rst_n by design.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= word_in;
    end

    assign bus.MISO = miso_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_ram_burst_slave
//   Directed and randomized frames against a word-level model of the RAM
//   (array + saturating write counter).
// ---------------------------------------------------------------------------
module tb_spi_ram_burst_slave;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int CMAX  = (1 << DW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    spi_ram_burst_slave_if bus_if ();

    spi_ram_burst_slave #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_fail   = 0;
    int err_seen = 0;

    logic [DW-1:0] model_mem [DEPTH];
    int            model_count = 0;

    // err is a one-cycle pulse, so sampling mid-cycle counts each pulse once.
    always @(negedge clk) if (bus_if.err === 1'b1) err_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] value, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus_if.ss_n = 1'b0;
            bus_if.MOSI = value[i];
            tick();
        end
    endtask

    task automatic end_frame();
        bus_if.ss_n = 1'b1;
        bus_if.MOSI = 1'b0;
        tick();
        tick();
    endtask

    task automatic write_burst(input int addr, input logic [DW-1:0] words[$]);
        int a;
        send(32'b00, 2);
        send(addr, AW);
        a = addr % DEPTH;
        foreach (words[i]) begin
            send(words[i], DW);
            model_mem[a] = words[i];
            a = (a + 1) % DEPTH;
            if (model_count < CMAX) model_count++;
        end
        end_frame();
    endtask

    task automatic shift_out(input int n_words, output logic [DW-1:0] got[$]);
        logic [DW-1:0] w;
        got.delete();
        for (int k = 0; k < n_words; k++) begin
            w = '0;
            for (int b = 0; b < DW; b++) begin
                bus_if.ss_n = 1'b0;
                bus_if.MOSI = 1'($urandom_range(0, 1));
                tick();
                w = {w[DW-2:0], bus_if.MISO};
            end
            got.push_back(w);
        end
    endtask

    task automatic check_read(input string tag, input int addr, input int n_words);
        logic [DW-1:0] got[$];
        int a;
        send(32'b01, 2);
        send(addr, AW);
        shift_out(n_words, got);
        end_frame();
        a = addr % DEPTH;
        foreach (got[i]) begin
            check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(model_mem[a]));
            a = (a + 1) % DEPTH;
        end
    endtask

    task automatic check_status(input string tag, input int n_words);
        logic [DW-1:0] got[$];
        send(32'b10, 2);
        shift_out(n_words, got);
        end_frame();
        foreach (got[i]) check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(model_count));
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] dummy[$];
        int            e0;
        int            a;
        int            n;
        logic          miso_or;

        bus_if.ss_n = 1'b1;
        bus_if.MOSI = 1'b0;
        rst_n       = 1'b0;
        repeat (3) tick();
        check("reset_miso", 32'(bus_if.MISO), 32'd0);
        check("reset_busy", 32'(bus_if.busy), 32'd0);
        check("reset_err",  32'(bus_if.err),  32'd0);
        rst_n = 1'b1;
        tick();

        // Basic burst write then read back with no gap between words.
        e0 = err_seen;
        q = '{8'hA5, 8'h3C};
        write_burst(8'h10, q);
        check("wr1_err",  32'(err_seen - e0), 32'd0);
        check("wr1_busy", 32'(bus_if.busy),   32'd0);
        e0 = err_seen;
        check_read("rd1", 8'h10, 2);
        check("rd1_err", 32'(err_seen - e0), 32'd0);

        // Wrap at the top of the array in both directions.
        q = '{8'h11, 8'h22};
        write_burst(8'hFF, q);
        check("wrap_mem0", 32'(model_mem[0]), 32'h22);
        check_read("rd_wrap", 8'hFF, 2);

        // Status streams the count, repeating while ss_n stays low.
        check_status("status4", 2);

        // Partial word: discarded, err pulses exactly once.
        e0 = err_seen;
        send(32'b00, 2);
        send(8'h10, AW);
        send(5'h1F, 5);
        end_frame();
        check("partial_err", 32'(err_seen - e0), 32'd1);
        check_read("partial_mem", 8'h10, 1);
        check_status("partial_cnt", 1);

        // Reserved opcode: one err pulse, MISO held low, busy during frame.
        e0      = err_seen;
        miso_or = 1'b0;
        send(32'b11, 2);
        check("rsvd_busy", 32'(bus_if.busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            bus_if.ss_n = 1'b0;
            bus_if.MOSI = 1'($urandom_range(0, 1));
            tick();
            miso_or = miso_or | bus_if.MISO;
        end
        end_frame();
        check("rsvd_err",  32'(err_seen - e0), 32'd1);
        check("rsvd_miso", 32'(miso_or),       32'd0);
        check("rsvd_busy_end", 32'(bus_if.busy), 32'd0);

        // Abort inside the address phase is an error; abort inside read is not.
        e0 = err_seen;
        send(32'b00, 2);
        send(4'h3, 4);
        end_frame();
        check("addr_abort_err", 32'(err_seen - e0), 32'd1);
        e0 = err_seen;
        send(32'b01, 2);
        send(8'h10, AW);
        send(3'h0, 3);
        end_frame();
        check("rd_abort_err", 32'(err_seen - e0), 32'd0);

        // Randomized bursts checked against the word-level model.
        for (int it = 0; it < 6; it++) begin
            a = $urandom_range(0, DEPTH - 1);
            n = $urandom_range(1, 4);
            q.delete();
            repeat (n) q.push_back(DW'($urandom));
            write_burst(a, q);
            check_read($sformatf("rand%0d", it), a, n);
        end
        check_status("status_rand", 1);

        // Long burst: wraps the whole array and saturates the count.
        a = $urandom_range(0, DEPTH - 1);
        q.delete();
        repeat (260) q.push_back(DW'($urandom));
        write_burst(a, q);
        check_status("status_sat", 2);
        check_read("long_rd", (a + 255) % DEPTH, 3);

        // Reset in the middle of a data word: no write, count cleared.
        a = 8'h20;
        send(32'b00, 2);
        send(a, AW);
        send(6'h2A, 6);
        rst_n = 1'b0;
        #2;
        check("midrst_busy", 32'(bus_if.busy), 32'd0);
        check("midrst_miso", 32'(bus_if.MISO), 32'd0);
        bus_if.ss_n = 1'b1;
        #2;
        rst_n = 1'b1;
        tick();
        model_count = 0;
        check_status("midrst_cnt", 1);
        check_read("midrst_mem", a, 1);

        dummy.delete();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
